// File: rtl/led_game_ctrl.sv
// led_game_ctrl: round sequencer for the switch-compare LED game.
// Runs the idle / fill / win-blink / lose-blink state machine, owns the tick
// divider, drives the 16-LED bank and keeps a saturating win counter.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | LEDs dark, divider parked at 0, waiting for start
//   RUN   | one LED lit per tick from LED15 down, waiting for a match
//   WIN   | LED15 blinks for 2*BLINKS ticks, then back to IDLE
//   LOSE  | whole bank blinks for 2*BLINKS ticks, then back to IDLE
module led_game_ctrl #(
    parameter int unsigned DIV_MAX = 1_000_000,
    parameter logic [3:0]  TARGET  = 4'b1010,
    parameter int unsigned BLINKS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic [1:0]  state_o,
    output logic        busy_o,
    output logic [7:0]  win_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    localparam logic [24:0] DIV_LAST   = 25'(DIV_MAX);
    localparam logic [4:0]  BLINK_LAST = 5'(2 * BLINKS - 1);
    localparam logic [15:0] WIN_PAT    = 16'h8000;
    localparam logic [15:0] LOSE_PAT   = 16'hFFFF;

    state_t      state_q, state_d;
    logic [24:0] div_q, div_d;
    logic [4:0]  led_cnt_q, led_cnt_d;
    logic [4:0]  blink_q, blink_d;
    logic [15:0] led_q, led_d;
    logic [7:0]  win_q, win_d;

    logic tick;
    logic match;
    logic unused_sw;

    assign tick      = (div_q == DIV_LAST);
    // Switches are assumed debounced/synchronised upstream.
    assign match     = (sw_i[3:0] == TARGET);
    assign unused_sw = ^sw_i[15:4];

    // Registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            led_cnt_q <= '0;
            blink_q   <= '0;
            led_q     <= '0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            led_cnt_q <= led_cnt_d;
            blink_q   <= blink_d;
            led_q     <= led_d;
            win_q     <= win_d;
        end
    end

    // Next-state, LED pattern, counters and divider.
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + 25'd1;
        led_cnt_d = led_cnt_q;
        blink_d   = blink_q;
        led_d     = led_q;
        win_d     = win_q;

        unique case (state_q)
            S_IDLE: begin
                div_d = '0;
                led_d = '0;
                if (start) begin
                    state_d   = S_RUN;
                    led_cnt_d = '0;
                end
            end
            S_RUN: begin
                // A match beats a simultaneous tick, even on the lose tick.
                if (match) begin
                    state_d = S_WIN;
                    led_d   = WIN_PAT;
                    blink_d = '0;
                    win_d   = (win_q == 8'hFF) ? win_q : win_q + 8'd1;
                end else if (tick) begin
                    if (led_cnt_q < 5'd16) begin
                        led_d     = led_q | (WIN_PAT >> led_cnt_q);
                        led_cnt_d = led_cnt_q + 5'd1;
                    end else begin
                        state_d = S_LOSE;
                        led_d   = LOSE_PAT;
                        blink_d = '0;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (tick) begin
                    if (blink_q == BLINK_LAST) begin
                        state_d = S_IDLE;
                        led_d   = '0;
                    end else begin
                        led_d   = (led_q != '0) ? 16'h0000
                                : ((state_q == S_WIN) ? WIN_PAT : LOSE_PAT);
                        blink_d = blink_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every state change restarts the tick period.
        if (state_d != state_q) begin
            div_d = '0;
        end
    end

    assign led_o     = led_q;
    assign state_o   = state_q;
    assign busy_o    = (state_q != S_IDLE);
    assign win_cnt_o = win_q;

endmodule

// File: tb/tb_led_game_ctrl.sv
// Bench for led_game_ctrl: directed scenarios plus random stimulus, all
// checked each cycle against a round-level reference model.
module tb_led_game_ctrl;

    localparam int DIV    = 3;
    localparam int BLINKS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic [1:0]  state_o;
    logic        busy_o;
    logic [7:0]  win_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: round state, cycles into the current tick period,
    // number of LEDs lit, blink phases elapsed, rounds won.
    int m_state = 0;
    int m_phase = 0;
    int m_fill  = 0;
    int m_blink = 0;
    int m_wins  = 0;

    led_game_ctrl #(
        .DIV_MAX (DIV),
        .TARGET  (4'hA),
        .BLINKS  (BLINKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sw_i      (sw_i),
        .led_o     (led_o),
        .state_o   (state_o),
        .busy_o    (busy_o),
        .win_cnt_o (win_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] model_led();
        logic [31:0] ones;
        case (m_state)
            1: begin
                ones = (32'd1 << m_fill) - 32'd1;
                return 16'(ones << (16 - m_fill));
            end
            2: return (m_blink % 2 == 0) ? 16'h8000 : 16'h0000;
            3: return (m_blink % 2 == 0) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input logic [15:0] sw);
        bit tk;
        tk = (m_phase == DIV);
        if (r) begin
            m_state = 0; m_phase = 0; m_fill = 0; m_blink = 0; m_wins = 0;
            return;
        end
        m_phase = tk ? 0 : m_phase + 1;
        case (m_state)
            0: begin
                m_phase = 0;
                if (s) begin m_state = 1; m_fill = 0; end
            end
            1: begin
                if (sw[3:0] == 4'hA) begin
                    m_state = 2; m_blink = 0; m_phase = 0;
                    if (m_wins < 255) m_wins++;
                end else if (tk) begin
                    if (m_fill < 16) m_fill++;
                    else begin m_state = 3; m_blink = 0; m_phase = 0; end
                end
            end
            default: begin
                if (tk) begin
                    if (m_blink == 2 * BLINKS - 1) begin m_state = 0; m_phase = 0; end
                    else m_blink++;
                end
            end
        endcase
    endtask

    // One clock: drive on the falling edge, update model on the rising edge,
    // compare all outputs shortly after.
    task automatic cycle(input bit r, input bit s, input logic [15:0] sw);
        @(negedge clk);
        rst = r; start = s; sw_i = sw;
        @(posedge clk);
        model_step(r, s, sw);
        #1;
        check("state", 32'(state_o), 32'(m_state));
        check("led", 32'(led_o), 32'(model_led()));
        check("busy", 32'(busy_o), 32'(m_state != 0));
        check("win_cnt", 32'(win_cnt_o), 32'(m_wins));
    endtask

    initial begin
        int t;
        bit hit;
        logic [15:0] sw_r;
        bit rst_r, start_r;

        rst = 1'b1; start = 1'b1; sw_i = '0;

        // Reset with start asserted, then first fill steps.
        cycle(1, 1, 16'h0);
        cycle(1, 1, 16'h0);
        check("rst_led", 32'(led_o), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        cycle(0, 1, 16'h0);
        check("run_entry", 32'(state_o), 32'h1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0);
        check("fill1", 32'(led_o), 32'h8000);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0);
        check("fill2", 32'(led_o), 32'hC000);

        // Lose path from a fresh round.
        cycle(1, 0, 16'h0);
        cycle(0, 1, 16'h0);
        t = 0; hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle(0, 0, 16'h0);
            t++;
            if (state_o == 2'd3) hit = 1;
        end
        check("lose_reached", 32'(hit), 32'h1);
        check("lose_latency", 32'(t), 32'(17 * (DIV + 1)));
        for (int i = 0; i < 2 * BLINKS * (DIV + 1); i++) cycle(0, 0, 16'h0);
        check("lose_idle", 32'(state_o), 32'h0);
        check("lose_wins", 32'(win_cnt_o), 32'h0);

        // Win mid-fill.
        cycle(0, 1, 16'h0);
        for (int i = 0; i < 5 * (DIV + 1); i++) cycle(0, 0, 16'h0);
        check("fill5", 32'(led_o), 32'hF800);
        cycle(0, 0, 16'h000A);
        check("win_state", 32'(state_o), 32'h2);
        check("win_led", 32'(led_o), 32'h8000);
        check("win_cnt1", 32'(win_cnt_o), 32'h1);
        for (int i = 0; i < 2 * BLINKS * (DIV + 1); i++) cycle(0, 0, 16'h000A);
        check("win_idle", 32'(state_o), 32'h0);

        // Match on the same cycle as the lose tick.
        cycle(0, 1, 16'h0);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_state == 1 && m_fill == 16 && m_phase == DIV) hit = 1;
            else cycle(0, 0, 16'h0);
        end
        check("race_reached", 32'(hit), 32'h1);
        check("race_full", 32'(led_o), 32'hFFFF);
        cycle(0, 0, 16'h000A);
        check("race_win", 32'(state_o), 32'h2);
        check("race_cnt", 32'(win_cnt_o), 32'h2);
        for (int i = 0; i < 2 * BLINKS * (DIV + 1); i++) cycle(0, 0, 16'h0);

        // Pre-matched rounds with start held: saturation of the win counter.
        cycle(1, 0, 16'h0);
        for (int i = 0; i < 256 * (2 + 2 * BLINKS * (DIV + 1)); i++) cycle(0, 1, 16'h000A);
        check("sat_cnt", 32'(win_cnt_o), 32'hFF);
        check("sat_idle", 32'(state_o), 32'h0);
        cycle(0, 1, 16'h000A);
        cycle(0, 1, 16'h000A);
        check("sat_hold", 32'(win_cnt_o), 32'hFF);
        for (int i = 0; i < 2 * BLINKS * (DIV + 1); i++) cycle(0, 0, 16'h0);

        // Reset during RUN and during LOSE.
        cycle(0, 1, 16'h0);
        for (int i = 0; i < 3 * (DIV + 1); i++) cycle(0, 0, 16'h0);
        check("pre_rst_led", 32'(led_o), 32'hE000);
        cycle(1, 0, 16'h0);
        check("mid_rst_led", 32'(led_o), 32'h0);
        check("mid_rst_cnt", 32'(win_cnt_o), 32'h0);
        cycle(0, 1, 16'h0);
        for (int i = 0; i < DIV; i++) cycle(0, 0, 16'h0);
        check("no_early_tick", 32'(led_o), 32'h0);
        cycle(0, 0, 16'h0);
        check("first_tick", 32'(led_o), 32'h8000);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle(0, 0, 16'h0);
            if (state_o == 2'd3) hit = 1;
        end
        check("lose2_reached", 32'(hit), 32'h1);
        cycle(0, 0, 16'h0);
        cycle(1, 0, 16'h0);
        check("lose_rst_state", 32'(state_o), 32'h0);
        check("lose_rst_led", 32'(led_o), 32'h0);

        // Random stimulus against the model.
        sw_r = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            rst_r   = ($urandom_range(0, 299) == 0);
            start_r = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0)
                sw_r = $urandom_range(0, 1) ? {16'($urandom) & 16'hFFF0} | 16'h000A
                                            : 16'($urandom);
            cycle(rst_r, start_r, sw_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
